stopwatch_ctrl_counter: RTL

- Consumer end of the 100 Hz tick interface: owns the stopwatch run/clear control FSM.
- Drives o_run/o_clear into the tick divider.
- Accumulates the returned 1-cycle tick pulses into cascaded centisecond/second/minute/hour counters for the FND display path.
- Sits between the debounced button block and the display mux.

---
 rtl/stopwatch_ctrl_counter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl_counter.sv
// Stopwatch run/stop/clear control FSM with cascaded centisecond..hour counters.
// Optional lap hold (frozen display, live counting) is enabled by STOPWATCH_LAP_HOLD_EN.
`timescale 1ns/1ps
module stopwatch_ctrl_counter #(
    parameter int unsigned MSEC_MAX = 100,
    parameter int unsigned SEC_MAX  = 60,
    parameter int unsigned MIN_MAX  = 60,
    parameter int unsigned HOUR_MAX = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_btn_run,
    input  logic                        i_btn_clear,
    input  logic                        i_btn_lap,
    input  logic                        i_tick,
    output logic                        o_run,
    output logic                        o_clear,
    output logic [$clog2(MSEC_MAX)-1:0] o_msec,
    output logic [$clog2(SEC_MAX)-1:0]  o_sec,
    output logic [$clog2(MIN_MAX)-1:0]  o_min,
    output logic [$clog2(HOUR_MAX)-1:0] o_hour,
    output logic                        o_day_wrap,
    output logic                        o_lap_hold
);
    localparam int unsigned MW = $clog2(MSEC_MAX);
    localparam int unsigned SW = $clog2(SEC_MAX);
    localparam int unsigned NW = $clog2(MIN_MAX);
    localparam int unsigned HW = $clog2(HOUR_MAX);

    localparam logic [MW-1:0] MSEC_LAST = MW'(MSEC_MAX - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_MAX - 1);
    localparam logic [NW-1:0] MIN_LAST  = NW'(MIN_MAX - 1);
    localparam logic [HW-1:0] HOUR_LAST = HW'(HOUR_MAX - 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   msec_q, msec_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic [NW-1:0]   min_q, min_d;
    logic [HW-1:0]   hour_q, hour_d;
    logic            wrap_q, wrap_d;
    logic            tick_en;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (i_btn_clear)    state_d = ST_CLEAR;
                else if (i_btn_run) state_d = ST_RUN;
            end
            ST_RUN:   if (i_btn_run) state_d = ST_STOP;
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    assign o_run   = (state_q == ST_RUN);
    assign o_clear = (state_q == ST_CLEAR);
    // Gate on the current state so a tick coinciding with the stop press still counts.
    assign tick_en = i_tick && (state_q == ST_RUN);

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        wrap_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick_en) begin
            if (msec_q != MSEC_LAST) begin
                msec_d = msec_q + MW'(1);
            end else begin
                msec_d = '0;
                if (sec_q != SEC_LAST) begin
                    sec_d = sec_q + SW'(1);
                end else begin
                    sec_d = '0;
                    if (min_q != MIN_LAST) begin
                        min_d = min_q + NW'(1);
                    end else begin
                        min_d = '0;
                        if (hour_q != HOUR_LAST) begin
                            hour_d = hour_q + HW'(1);
                        end else begin
                            hour_d = '0;
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOP;
            msec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_day_wrap = wrap_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic            hold_q, hold_d;
    logic [MW-1:0]   cap_msec_q, cap_msec_d;
    logic [SW-1:0]   cap_sec_q, cap_sec_d;
    logic [NW-1:0]   cap_min_q, cap_min_d;
    logic [HW-1:0]   cap_hour_q, cap_hour_d;

    always_comb begin
        hold_d     = hold_q;
        cap_msec_d = cap_msec_q;
        cap_sec_d  = cap_sec_q;
        cap_min_d  = cap_min_q;
        cap_hour_d = cap_hour_q;
        if (state_d == ST_CLEAR) begin
            hold_d     = 1'b0;
            cap_msec_d = '0;
            cap_sec_d  = '0;
            cap_min_d  = '0;
            cap_hour_d = '0;
        end else if ((state_q == ST_RUN) && i_btn_lap) begin
            hold_d = !hold_q;
            if (!hold_q) begin
                cap_msec_d = msec_q;
                cap_sec_d  = sec_q;
                cap_min_d  = min_q;
                cap_hour_d = hour_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= 1'b0;
            cap_msec_q <= '0;
            cap_sec_q  <= '0;
            cap_min_q  <= '0;
            cap_hour_q <= '0;
        end else begin
            hold_q     <= hold_d;
            cap_msec_q <= cap_msec_d;
            cap_sec_q  <= cap_sec_d;
            cap_min_q  <= cap_min_d;
            cap_hour_q <= cap_hour_d;
        end
    end

    assign o_lap_hold = hold_q;
    assign o_msec     = hold_q ? cap_msec_q : msec_q;
    assign o_sec      = hold_q ? cap_sec_q  : sec_q;
    assign o_min      = hold_q ? cap_min_q  : min_q;
    assign o_hour     = hold_q ? cap_hour_q : hour_q;
`else
    logic unused_lap;
    assign unused_lap = i_btn_lap;
    assign o_lap_hold = 1'b0;
    assign o_msec     = msec_q;
    assign o_sec      = sec_q;
    assign o_min      = min_q;
    assign o_hour     = hour_q;
`endif

endmodule
